sync_fifo_lvl: RTL and testbench

SYNC_FIFO_LVL -- requirements
Module: sync_fifo_lvl

---
 rtl/sync_fifo_lvl_if.sv | 29 ++
 rtl/sync_fifo_lvl.sv | 113 +++++++++++
 tb/tb_sync_fifo_lvl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_lvl_if.sv
// rtl/sync_fifo_lvl_if.sv - source/destination handshake bundle for sync_fifo_lvl
interface sync_fifo_lvl_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] src_data_i;
  logic                  src_valid_i;
  logic                  src_ready_o;
  logic [DATA_WIDTH-1:0] dst_data_o;
  logic                  dst_valid_o;
  logic                  dst_ready_i;

  modport slave (
    input  src_data_i,
    input  src_valid_i,
    output src_ready_o,
    output dst_data_o,
    output dst_valid_o,
    input  dst_ready_i
  );

  modport master (
    output src_data_i,
    output src_valid_i,
    input  src_ready_o,
    input  dst_data_o,
    input  dst_valid_o,
    output dst_ready_i
  );
endinterface

// File: rtl/sync_fifo_lvl.sv
// rtl/sync_fifo_lvl.sv - synchronous FIFO with level, almost-full/empty flags and high-water mark
module sync_fifo_lvl #(
  parameter int DATA_WIDTH       = 32,
  parameter int BUFFER_DEPTH     = 8,
  parameter int FALL_THROUGH     = 0,
  parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  sync_fifo_lvl_if.slave            bus,
  input  logic [LOG_BUFFER_DEPTH:0] af_thr_i,
  input  logic [LOG_BUFFER_DEPTH:0] ae_thr_i,
  output logic [LOG_BUFFER_DEPTH:0] level_o,
  output logic                      almost_full_o,
  output logic                      almost_empty_o,
  input  logic                      peak_clr_i,
  output logic [LOG_BUFFER_DEPTH:0] peak_o
);

  localparam int LW = LOG_BUFFER_DEPTH + 1;
  localparam logic [LOG_BUFFER_DEPTH-1:0] LAST_IDX = LOG_BUFFER_DEPTH'(BUFFER_DEPTH - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0]       mem_q [BUFFER_DEPTH];
  logic [LOG_BUFFER_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_BUFFER_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]               level_q, level_d;
  logic [LW-1:0]               peak_q, peak_d;

  logic empty, full, push, pop, bypass, wr_en;

  function automatic logic [LOG_BUFFER_DEPTH-1:0] ptr_inc(input logic [LOG_BUFFER_DEPTH-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LVL);

  // Readiness looks only at the registered level, so a same-cycle pop never frees a slot early.
  assign bus.src_ready_o = ~rst_i & ~flush_i & ~full;

  generate
    if (FALL_THROUGH != 0) begin : g_ft
      assign bus.dst_valid_o = ~rst_i & ~flush_i & (~empty | bus.src_valid_i);
      assign bus.dst_data_o  = empty ? bus.src_data_i : mem_q[rd_ptr_q];
      // A pop while empty can only be the incoming word passing straight through.
      assign bypass          = empty & push & pop;
    end else begin : g_reg
      assign bus.dst_valid_o = ~rst_i & ~flush_i & ~empty;
      assign bus.dst_data_o  = mem_q[rd_ptr_q];
      assign bypass          = 1'b0;
    end
  endgenerate

  assign push  = bus.src_valid_i & bus.src_ready_o;
  assign pop   = bus.dst_valid_o & bus.dst_ready_i;
  assign wr_en = push & ~bypass;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else if (!bypass) begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    peak_d = peak_q;
    if (peak_clr_i) begin
      peak_d = level_d;
    end else if (level_d > peak_q) begin
      peak_d = level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      peak_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      peak_q   <= peak_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.src_data_i;
    end
  end

  assign level_o        = level_q;
  assign peak_o         = peak_q;
  assign almost_full_o  = (level_q >= af_thr_i);
  assign almost_empty_o = (level_q <= ae_thr_i);

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// tb/tb_sync_fifo_lvl.sv - randomized and directed bench for sync_fifo_lvl against a queue model
module tb_sync_fifo_lvl;

  localparam int NI = 3;

  logic        clk;
  logic        rs, fl, sv, dr, pc;
  logic [31:0] sd;
  logic [3:0]  aft, aet;

  logic        rdy  [NI];
  logic        vld  [NI];
  logic [31:0] dout [NI];
  logic [3:0]  lvl  [NI];
  logic [3:0]  pk   [NI];
  logic        af   [NI];
  logic        ae   [NI];

  int          depth_m [NI] = '{8, 5, 8};
  bit          ft_m    [NI] = '{1'b0, 1'b0, 1'b1};
  logic [31:0] mq      [NI][$];
  int          pkm     [NI];
  bit          started;

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D = (g == 1) ? 5 : 8;
    localparam int F = (g == 2) ? 1 : 0;
    sync_fifo_lvl_if #(.DATA_WIDTH(32)) u_if ();
    assign u_if.src_data_i  = sd;
    assign u_if.src_valid_i = sv;
    assign u_if.dst_ready_i = dr;
    assign rdy[g]  = u_if.src_ready_o;
    assign vld[g]  = u_if.dst_valid_o;
    assign dout[g] = u_if.dst_data_o;
    sync_fifo_lvl #(.DATA_WIDTH(32), .BUFFER_DEPTH(D), .FALL_THROUGH(F)) u_dut (
      .clk_i         (clk),
      .rst_i         (rs),
      .flush_i       (fl),
      .bus           (u_if),
      .af_thr_i      (aft),
      .ae_thr_i      (aet),
      .level_o       (lvl[g]),
      .almost_full_o (af[g]),
      .almost_empty_o(ae[g]),
      .peak_clr_i    (pc),
      .peak_o        (pk[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: apply inputs, check outputs against the model, then advance the model.
  task automatic step(input bit r, input bit f, input bit v, input logic [31:0] d,
                      input bit rin, input bit pcl);
    int cnt, nl;
    bit e_rdy, e_vld, ps, pp;
    @(negedge clk);
    rs = r; fl = f; sv = v; sd = d; dr = rin; pc = pcl;
    #1;
    for (int i = 0; i < NI; i++) begin
      cnt   = mq[i].size();
      e_rdy = !r && !f && (cnt != depth_m[i]);
      e_vld = !r && !f && (cnt > 0 || (ft_m[i] && v));
      ps    = v && e_rdy;
      pp    = e_vld && rin;
      chk($sformatf("i%0d ready", i), {31'b0, rdy[i]}, {31'b0, e_rdy});
      chk($sformatf("i%0d valid", i), {31'b0, vld[i]}, {31'b0, e_vld});
      if (e_vld) chk($sformatf("i%0d data", i), dout[i], (cnt > 0) ? mq[i][0] : d);
      if (started) begin
        chk($sformatf("i%0d level", i), {28'b0, lvl[i]}, cnt);
        chk($sformatf("i%0d afull", i), {31'b0, af[i]}, {31'b0, cnt >= int'(aft)});
        chk($sformatf("i%0d aempty", i), {31'b0, ae[i]}, {31'b0, cnt <= int'(aet)});
        chk($sformatf("i%0d peak", i), {28'b0, pk[i]}, pkm[i]);
      end
      if (r) begin
        mq[i].delete();
        pkm[i] = 0;
      end else begin
        if (f) begin
          mq[i].delete();
        end else if (!(pp && cnt == 0)) begin
          if (pp) void'(mq[i].pop_front());
          if (ps) mq[i].push_back(d);
        end
        nl = mq[i].size();
        pkm[i] = pcl ? nl : ((nl > pkm[i]) ? nl : pkm[i]);
      end
    end
    if (r) started = 1'b1;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rs = 1; fl = 0; sv = 0; dr = 0; pc = 0; sd = 0; aft = 4'd8; aet = 4'd0;
    started = 1'b0;
    for (int i = 0; i < NI; i++) pkm[i] = 0;

    do_reset();
    step(0, 0, 0, 0, 0, 0);
    chk("post_rst_level", {28'b0, lvl[0]}, 0);
    chk("post_rst_ready", {31'b0, rdy[0]}, 1);

    // Fill the depth-8 FIFO with 1..8, attempt a 9th, then drain in order.
    for (int k = 1; k <= 8; k++) step(0, 0, 1, k, 0, 0);
    step(0, 0, 1, 9, 0, 0);
    chk("full_level", {28'b0, lvl[0]}, 8);
    chk("full_ready", {31'b0, rdy[0]}, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 0, 1, 0);
      chk($sformatf("drain%0d", k), dout[0], k);
    end

    // Depth-5 steady stream at level 2 across pointer wrap.
    do_reset();
    step(0, 0, 1, 32'h100, 0, 0);
    step(0, 0, 1, 32'h101, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 1, 32'h102 + k, 1, 0);
      if (k > 0) chk("d5_level", {28'b0, lvl[1]}, 2);
      chk("d5_order", dout[1], 32'h100 + k);
    end

    // Fall-through bypass into an empty FIFO.
    do_reset();
    step(0, 0, 1, 32'hA5, 1, 0);
    chk("ft_valid", {31'b0, vld[2]}, 1);
    chk("ft_data", dout[2], 32'hA5);
    step(0, 0, 0, 0, 0, 0);
    chk("ft_level", {28'b0, lvl[2]}, 0);

    // Flush at level 6 with concurrent push and pop.
    do_reset();
    for (int k = 0; k < 6; k++) step(0, 0, 1, 32'h200 + k, 0, 0);
    aft = 4'd6; aet = 4'd2;
    step(0, 1, 1, 32'h2FF, 1, 0);
    chk("flush_valid", {31'b0, vld[0]}, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("flush_level", {28'b0, lvl[0]}, 0);
    chk("flush_afull", {31'b0, af[0]}, 0);
    chk("flush_aempty", {31'b0, ae[0]}, 1);
    chk("flush_peak", {28'b0, pk[0]}, 6);

    // High-water mark: fill to 7, drain to 3, clear.
    do_reset();
    for (int k = 0; k < 7; k++) step(0, 0, 1, 32'h300 + k, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("peak_before", {28'b0, pk[0]}, 7);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("peak_after", {28'b0, pk[0]}, 3);

    // Reset with stored words.
    for (int k = 0; k < 1; k++) step(0, 0, 1, 32'h400, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_level", {28'b0, lvl[0]}, 0);
    chk("rst_valid", {31'b0, vld[0]}, 0);
    chk("rst_peak", {28'b0, pk[0]}, 0);
    chk("rst_ready", {31'b0, rdy[0]}, 1);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      aft = 4'($urandom_range(0, 9));
      aet = 4'($urandom_range(0, 9));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 3) != 0, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
